// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher: state encoding, default widths
// and the length-to-reload conversion used at every pulse start.
package pulse_stretch_pkg;

    localparam int LEN_BITS_DEF  = 8;
    localparam int PEND_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    // A length of 0 behaves as 1, so the reload value is max(len,1)-1.
    function automatic logic [31:0] len_to_reload(input logic [31:0] len_val);
        return (len_val == 32'd0) ? 32'd0 : len_val - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_len_counter.sv
// Loadable down-counter that times the active phase of each pulse.
// It stops at zero; load has priority over dec.
module pulse_len_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Turns single-cycle strobes into pulses of max(len,1) cycles with a 1-cycle gap between pulses.
// PULSE_STRETCH_RETRIGGER_EN selects retriggerable mode instead of queuing extra events.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int LEN_BITS     = LEN_BITS_DEF,
    parameter int PEND_BITS    = PEND_BITS_DEF,
    parameter bit OUT_POLARITY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic [LEN_BITS-1:0]  len,
    output logic                 out,
    output logic                 busy,
    output logic [PEND_BITS-1:0] pending,
    output logic                 overflow
);

    localparam logic OUT_ACT  = OUT_POLARITY;
    localparam logic OUT_IDLE = ~OUT_POLARITY;

    state_e              state_q;
    logic                out_q;
    logic                busy_q;
    logic                cnt_load_d;
    logic                cnt_dec_d;
    logic                cnt_zero;
    logic [LEN_BITS-1:0] reload_d;

    assign reload_d = LEN_BITS'(len_to_reload(32'(len)));

`ifndef PULSE_STRETCH_RETRIGGER_EN
    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
    logic [PEND_BITS-1:0] pending_q;
    logic                 overflow_q;
`endif

    always_comb begin
        cnt_load_d = 1'b0;
        cnt_dec_d  = 1'b0;
        case (state_q)
            IDLE: cnt_load_d = in;
`ifdef PULSE_STRETCH_RETRIGGER_EN
            ACTIVE: begin
                cnt_load_d = in;
                cnt_dec_d  = ~in;
            end
            GAP: cnt_load_d = in;
`else
            ACTIVE: cnt_dec_d = 1'b1;
            GAP: cnt_load_d = in || (pending_q != '0);
`endif
            default: begin
                cnt_load_d = 1'b0;
                cnt_dec_d  = 1'b0;
            end
        endcase
    end

    pulse_len_counter #(
        .W (LEN_BITS)
    ) u_len_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_d),
        .load_val (reload_d),
        .dec      (cnt_dec_d),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= OUT_IDLE;
            busy_q     <= 1'b0;
`ifndef PULSE_STRETCH_RETRIGGER_EN
            pending_q  <= '0;
            overflow_q <= 1'b0;
`endif
        end else begin
`ifndef PULSE_STRETCH_RETRIGGER_EN
            overflow_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (in) begin
                        state_q <= ACTIVE;
                        out_q   <= OUT_ACT;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (!in && cnt_zero) begin
                        state_q <= GAP;
                        out_q   <= OUT_IDLE;
                    end
`else
                    if (in) begin
                        if (pending_q == PEND_MAX) begin
                            overflow_q <= 1'b1;
                        end else begin
                            pending_q <= pending_q + 1'b1;
                        end
                    end
                    if (cnt_zero) begin
                        state_q <= GAP;
                        out_q   <= OUT_IDLE;
                    end
`endif
                end
                GAP: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (in) begin
                        state_q <= ACTIVE;
                        out_q   <= OUT_ACT;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    // A strobe arriving while a queued event is released nets to no change.
                    if (pending_q != '0) begin
                        state_q <= ACTIVE;
                        out_q   <= OUT_ACT;
                        if (!in) begin
                            pending_q <= pending_q - 1'b1;
                        end
                    end else if (in) begin
                        state_q <= ACTIVE;
                        out_q   <= OUT_ACT;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= OUT_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
`ifdef PULSE_STRETCH_RETRIGGER_EN
    assign pending  = '0;
    assign overflow = 1'b0;
`else
    assign pending  = pending_q;
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three instances (default, 2-bit pending, active-low out)
// checked every cycle against an event-level model, plus directed literal checks.
module tb_pulse_stretch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_s = 1'b0;
    logic [7:0] len_s = 8'd0;

    logic [2:0] out_v, busy_v, ovf_v;
    logic [3:0] pend0, pend2;
    logic [1:0] pend1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pulse_stretch u_d0 (
        .clk(clk), .reset(reset), .in(in_s), .len(len_s),
        .out(out_v[0]), .busy(busy_v[0]), .pending(pend0), .overflow(ovf_v[0])
    );
    pulse_stretch #(.PEND_BITS(2)) u_d1 (
        .clk(clk), .reset(reset), .in(in_s), .len(len_s),
        .out(out_v[1]), .busy(busy_v[1]), .pending(pend1), .overflow(ovf_v[1])
    );
    pulse_stretch #(.OUT_POLARITY(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .in(in_s), .len(len_s),
        .out(out_v[2]), .busy(busy_v[2]), .pending(pend2), .overflow(ovf_v[2])
    );

    // Event-level model: remaining active cycles, a gap flag and a count of queued events.
    int m_rem [3];
    bit m_gap [3];
    int m_pend[3];
    bit m_ovf [3];
    int m_max [3] = '{15, 3, 15};
    bit m_pol [3] = '{1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int l;
        l = (len_s == 8'd0) ? 1 : int'(len_s);
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_gap[k] = 1'b0; m_pend[k] = 0; m_ovf[k] = 1'b0;
            end else begin
                m_ovf[k] = 1'b0;
                if (m_rem[k] > 0) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
                    if (in_s) m_rem[k] = l;
                    else m_rem[k] = m_rem[k] - 1;
`else
                    if (in_s) begin
                        if (m_pend[k] == m_max[k]) m_ovf[k] = 1'b1;
                        else m_pend[k] = m_pend[k] + 1;
                    end
                    m_rem[k] = m_rem[k] - 1;
`endif
                    if (m_rem[k] == 0) m_gap[k] = 1'b1;
                end else if (m_gap[k]) begin
                    m_gap[k] = 1'b0;
                    if (m_pend[k] > 0) begin
                        m_rem[k] = l;
                        if (!in_s) m_pend[k] = m_pend[k] - 1;
                    end else if (in_s) begin
                        m_rem[k] = l;
                    end
                end else if (in_s) begin
                    m_rem[k] = l;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0; m_gap[k] = 1'b0; m_pend[k] = 0; m_ovf[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    int act;
                    int p;
                    act = (m_rem[k] > 0) ? 1 : 0;
                    p = (k == 0) ? int'(pend0) : (k == 1) ? int'(pend1) : int'(pend2);
                    check($sformatf("d%0d.out", k), int'(out_v[k]), m_pol[k] ? act : 1 - act);
                    check($sformatf("d%0d.busy", k), int'(busy_v[k]),
                          ((m_rem[k] > 0) || m_gap[k]) ? 1 : 0);
                    check($sformatf("d%0d.pending", k), p, m_pend[k]);
                    check($sformatf("d%0d.overflow", k), int'(ovf_v[k]), int'(m_ovf[k]));
                end
            end
        end
    end

    // Drive one cycle of inputs; returns at the next negedge with post-edge outputs visible.
    task automatic cyc(input bit i_in, input int i_len, input bit i_rst);
        in_s  = i_in;
        len_s = 8'(i_len);
        reset = i_rst;
        @(negedge clk);
    endtask

    task automatic pulse_width(input int l_start, input int l_during, output int width);
        cyc(1'b1, l_start, 1'b0);
        width = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_v[0]) width++;
            cyc(1'b0, l_during, 1'b0);
        end
    endtask

    initial begin
        int w;
        int hi;
        int falls;
        int rises0;
        int rises1;
        bit prev0;
        bit prev1;

        for (int i = 0; i < 3; i++) cyc(1'b0, 4, 1'b1);
        chk_en = 1'b1;
        check("rst.out", int'(out_v[0]), 0);
        check("rst.busy", int'(busy_v[0]), 0);
        check("rst.pending", int'(pend0), 0);
        check("rst.overflow", int'(ovf_v[0]), 0);
        check("rst.out_low_pol", int'(out_v[2]), 1);
        cyc(1'b0, 4, 1'b0);

        // Single event, len=4: active t+1..t+4, gap at t+5, idle at t+6.
        cyc(1'b1, 4, 1'b0);
        check("single.first_out", int'(out_v[0]), 1);
        check("single.first_out_low_pol", int'(out_v[2]), 0);
        hi = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4, 1'b0);
            hi += int'(out_v[0]);
        end
        check("single.width", hi, 4);
        cyc(1'b0, 4, 1'b0);
        check("single.gap_out", int'(out_v[0]), 0);
        check("single.gap_busy", int'(busy_v[0]), 1);
        cyc(1'b0, 4, 1'b0);
        check("single.idle_busy", int'(busy_v[0]), 0);

        pulse_width(0, 0, w);
        check("len0.width", w, 1);
        pulse_width(1, 1, w);
        check("len1.width", w, 1);
        pulse_width(4, 7, w);
        check("lenchg.width", w, 4);
        pulse_width(7, 7, w);
        check("len7.width", w, 7);

`ifdef PULSE_STRETCH_RETRIGGER_EN
        hi = 0;
        falls = 0;
        prev0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc((i == 0) || (i == 3), 5, 1'b0);
            hi += int'(out_v[0]);
            if (prev0 && !out_v[0]) falls++;
            prev0 = out_v[0];
            if (pend0 != 4'd0 || ovf_v[0]) check("retrig.no_queue", 1, 0);
        end
        check("retrig.width", hi, 8);
        check("retrig.falls", falls, 1);
`else
        // Three back-to-back strobes, len=3: three pulses separated by one idle cycle.
        cyc(1'b1, 3, 1'b0);
        cyc(1'b1, 3, 1'b0);
        cyc(1'b1, 3, 1'b0);
        check("queue.pending", int'(pend0), 2);
        falls = 0;
        prev0 = out_v[0];
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 3, 1'b0);
            if (prev0 && !out_v[0]) falls++;
            prev0 = out_v[0];
        end
        check("queue.falls", falls, 3);
        check("queue.pending_end", int'(pend0), 0);

        // Saturation: start + 4 extra strobes, len=20.
        cyc(1'b1, 20, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 20, 1'b0);
        check("sat.pending_d1", int'(pend1), 3);
        check("sat.overflow_d1", int'(ovf_v[1]), 1);
        check("sat.pending_d0", int'(pend0), 4);
        check("sat.overflow_d0", int'(ovf_v[0]), 0);
        cyc(1'b0, 20, 1'b0);
        check("sat.overflow_clear", int'(ovf_v[1]), 0);
        rises0 = 1;
        rises1 = 1;
        prev0 = out_v[0];
        prev1 = out_v[1];
        for (int i = 0; i < 110; i++) begin
            cyc(1'b0, 20, 1'b0);
            if (!prev0 && out_v[0]) rises0++;
            if (!prev1 && out_v[1]) rises1++;
            prev0 = out_v[0];
            prev1 = out_v[1];
        end
        check("sat.pulses_d1", rises1, 4);
        check("sat.pulses_d0", rises0, 5);
`endif

        // Reset on the 4th cycle of a 10-cycle pulse with an event queued.
        cyc(1'b1, 10, 1'b0);
        cyc(1'b1, 10, 1'b0);
        cyc(1'b0, 10, 1'b0);
        cyc(1'b0, 10, 1'b0);
        cyc(1'b0, 10, 1'b1);
        check("midrst.out", int'(out_v[0]), 0);
        check("midrst.busy", int'(busy_v[0]), 0);
        check("midrst.pending", int'(pend0), 0);
        check("midrst.out_low_pol", int'(out_v[2]), 1);
        pulse_width(10, 10, w);
        check("midrst.next_width", w, 10);

        for (int i = 0; i < 4000; i++) begin
            int r;
            int l;
            r = int'($urandom_range(0, 99));
            l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(0, 6));
            cyc(r < 35, l, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 40; i++) cyc(1'b0, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
